// File: rtl/digit_counter_pkg.sv
// Shared types and constants for the two-digit button-driven counter.
package digit_counter_pkg;

  // Debounce FSM states for one pushbutton.
  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } db_state_t;

  localparam int DIGIT_W  = 4;

  // The only radices the seven-segment stage is wired for.
  localparam int BASE_DEC = 10;
  localparam int BASE_HEX = 16;

  function automatic bit base_legal(input int base);
    return (base == BASE_DEC) || (base == BASE_HEX);
  endfunction

endpackage

// File: rtl/button_conditioner.sv
// One pushbutton: 2-FF synchronizer, debounce FSM and a single-cycle press pulse.
module button_conditioner
  import digit_counter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic press
);

  // A width of at least one bit keeps DEBOUNCE_CYCLES = 1 legal.
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_ff;
  logic             level;
  db_state_t        state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;

  // Synchronizer idles at 1 (button released).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_ff <= 2'b11;
    else        sync_ff <= {sync_ff[0], btn_n};
  end

  assign level = sync_ff[1];

  // FSM state and debounce counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic; press fires on the PRESS_WAIT -> HELD transition only,
  // so a held button never repeats. The counter saturates at all ones.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    press      = 1'b0;
    unique case (state)
      IDLE: begin
        if (!level) begin
          state_next = PRESS_WAIT;
          cnt_next   = '0;
        end
      end
      PRESS_WAIT: begin
        if (level) begin
          state_next = IDLE;
        end else if (cnt == CNT_LAST) begin
          state_next = HELD;
          press      = 1'b1;
        end else begin
          cnt_next = (cnt == '1) ? cnt : cnt + 1'b1;
        end
      end
      HELD: begin
        if (level) begin
          state_next = RELEASE_WAIT;
          cnt_next   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (!level) begin
          state_next = HELD;
        end else if (cnt == CNT_LAST) begin
          state_next = IDLE;
        end else begin
          cnt_next = (cnt == '1) ? cnt : cnt + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: rtl/digit_counter.sv
// Two-digit up/down counter (decimal or hex) stepped by debounced pushbuttons.
module digit_counter
  import digit_counter_pkg::*;
#(
  parameter int BASE            = 10,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               btn_inc_n,
  input  logic               btn_dec_n,
  input  logic               clr,
  input  logic               en,
  output logic [DIGIT_W-1:0] digit0,
  output logic [DIGIT_W-1:0] digit1,
  output logic               wrap
);

  if (!base_legal(BASE)) begin : g_bad_base
    $error("digit_counter: BASE must be 10 or 16");
  end

  localparam logic [DIGIT_W-1:0] DMAX = DIGIT_W'(BASE - 1);

  logic               inc_press, dec_press;
  logic [DIGIT_W-1:0] d0_next, d1_next;
  logic               wrap_next;

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_n (btn_inc_n),
    .press (inc_press)
  );

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dec (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_n (btn_dec_n),
    .press (dec_press)
  );

  // Priority: clear, enable, conflicting presses, then inc or dec with carry/borrow.
  // Presses not acted on here are dropped, never queued.
  always_comb begin
    d0_next   = digit0;
    d1_next   = digit1;
    wrap_next = 1'b0;
    if (clr) begin
      d0_next = '0;
      d1_next = '0;
    end else if (!en || (inc_press && dec_press)) begin
      // hold
    end else if (inc_press) begin
      if (digit0 == DMAX) begin
        d0_next = '0;
        if (digit1 == DMAX) begin
          d1_next   = '0;
          wrap_next = 1'b1;
        end else begin
          d1_next = digit1 + 1'b1;
        end
      end else begin
        d0_next = digit0 + 1'b1;
      end
    end else if (dec_press) begin
      if (digit0 == '0) begin
        d0_next = DMAX;
        if (digit1 == '0) begin
          d1_next   = DMAX;
          wrap_next = 1'b1;
        end else begin
          d1_next = digit1 - 1'b1;
        end
      end else begin
        d0_next = digit0 - 1'b1;
      end
    end
  end

  // Digit registers and the wrap pulse, updated together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit0 <= '0;
      digit1 <= '0;
      wrap   <= 1'b0;
    end else begin
      digit0 <= d0_next;
      digit1 <= d1_next;
      wrap   <= wrap_next;
    end
  end

endmodule

// File: tb/tb_digit_counter.sv
// Directed bench: decimal and hex instances share stimulus, DEBOUNCE_CYCLES = 4.
module tb_digit_counter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_inc_n = 1'b1;
  logic       btn_dec_n = 1'b1;
  logic       clr = 1'b0;
  logic       en = 1'b1;
  logic [3:0] d0_d, d1_d, d0_h, d1_h;
  logic       wrap_d, wrap_h;

  int vectors = 0;
  int miscompares = 0;
  int wd, wh;

  always #5 clk = ~clk;

  digit_counter #(.BASE(10), .DEBOUNCE_CYCLES(4)) u_dec (
    .clk(clk), .rst_n(rst_n), .btn_inc_n(btn_inc_n), .btn_dec_n(btn_dec_n),
    .clr(clr), .en(en), .digit0(d0_d), .digit1(d1_d), .wrap(wrap_d)
  );

  digit_counter #(.BASE(16), .DEBOUNCE_CYCLES(4)) u_hex (
    .clk(clk), .rst_n(rst_n), .btn_inc_n(btn_inc_n), .btn_dec_n(btn_dec_n),
    .clr(clr), .en(en), .digit0(d0_h), .digit1(d1_h), .wrap(wrap_h)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_dec(input string tag, input logic [7:0] exp);
    chk(tag, {d1_d, d0_d}, exp);
  endtask

  task automatic chk_hex(input string tag, input logic [7:0] exp);
    chk(tag, {d1_h, d0_h}, exp);
  endtask

  // Hold the chosen buttons low for 'low' cycles then release for 12 cycles,
  // counting the wrap pulses seen on each instance.
  task automatic press(input bit inc, input bit dec, input int low,
                       output int wrap_d_cnt, output int wrap_h_cnt);
    wrap_d_cnt = 0;
    wrap_h_cnt = 0;
    @(posedge clk); #1;
    if (inc) btn_inc_n = 1'b0;
    if (dec) btn_dec_n = 1'b0;
    for (int i = 0; i < low; i++) begin
      @(posedge clk); #1;
      wrap_d_cnt += int'(wrap_d);
      wrap_h_cnt += int'(wrap_h);
    end
    btn_inc_n = 1'b1;
    btn_dec_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      wrap_d_cnt += int'(wrap_d);
      wrap_h_cnt += int'(wrap_h);
    end
  endtask

  task automatic do_clr();
    @(posedge clk); #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
  endtask

  initial begin
    // Reset with both buttons held.
    btn_inc_n = 1'b0;
    btn_dec_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_dec("reset_digits", 8'h00);
    chk("reset_wrap", {7'd0, wrap_d}, 8'h00);
    btn_dec_n = 1'b1;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1 chk_dec("post_reset_edge6", 8'h00);
    @(posedge clk);
    #1 chk_dec("post_reset_edge7", 8'h01);
    btn_inc_n = 1'b1;
    repeat (12) @(posedge clk);

    // Short glitch, normal press, long hold.
    press(1, 0, 3, wd, wh);
    chk_dec("glitch3", 8'h01);
    press(1, 0, 10, wd, wh);
    chk_dec("press10", 8'h02);
    press(1, 0, 100, wd, wh);
    chk_dec("hold100", 8'h03);

    // Decimal carry 09 -> 10.
    for (int i = 0; i < 6; i++) press(1, 0, 10, wd, wh);
    chk_dec("dec_at09", 8'h09);
    press(1, 0, 10, wd, wh);
    chk_dec("dec_09_to_10", 8'h10);
    chk_hex("hex_0a", 8'h0a);

    // Hex carry 0F -> 10.
    for (int i = 0; i < 5; i++) press(1, 0, 10, wd, wh);
    chk_hex("hex_at0f", 8'h0f);
    press(1, 0, 10, wd, wh);
    chk_hex("hex_0f_to_10", 8'h10);
    chk_dec("dec_16", 8'h16);

    // Underflow and overflow with wrap.
    do_clr();
    chk_dec("clr", 8'h00);
    press(0, 1, 10, wd, wh);
    chk_dec("dec_00_to_99", 8'h99);
    chk_hex("hex_00_to_ff", 8'hff);
    chk("dec_wrap_under", 8'(wd), 8'd1);
    chk("hex_wrap_under", 8'(wh), 8'd1);
    press(1, 0, 10, wd, wh);
    chk_dec("dec_99_to_00", 8'h00);
    chk_hex("hex_ff_to_00", 8'h00);
    chk("dec_wrap_over", 8'(wd), 8'd1);
    chk("hex_wrap_over", 8'(wh), 8'd1);

    // Simultaneous presses at 42.
    for (int i = 0; i < 42; i++) press(1, 0, 10, wd, wh);
    chk_dec("dec_at42", 8'h42);
    press(1, 1, 10, wd, wh);
    chk_dec("both_hold", 8'h42);
    chk_hex("both_hold_hex", 8'h2a);
    chk("both_no_wrap", 8'(wd), 8'd0);

    // Press while disabled is dropped.
    en = 1'b0;
    press(1, 0, 10, wd, wh);
    chk_dec("en0_hold", 8'h42);
    en = 1'b1;
    repeat (20) @(posedge clk);
    #1 chk_dec("en_rise_no_step", 8'h42);

    // clr on the same cycle as the press pulse at 57.
    for (int i = 0; i < 15; i++) press(1, 0, 10, wd, wh);
    chk_dec("dec_at57", 8'h57);
    chk_hex("hex_at39", 8'h39);
    @(posedge clk); #1 btn_inc_n = 1'b0;
    repeat (6) @(posedge clk);
    #1 clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    chk_dec("clr_vs_press", 8'h00);
    chk("clr_no_wrap", {7'd0, wrap_d}, 8'h00);
    btn_inc_n = 1'b1;
    repeat (12) @(posedge clk);
    #1 chk_dec("clr_press_dropped", 8'h00);

    // Reset asserted mid PRESS_WAIT.
    press(1, 0, 10, wd, wh);
    chk_dec("pre_rst_01", 8'h01);
    @(posedge clk); #1 btn_inc_n = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk_dec("rst_async", 8'h00);
    btn_inc_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1 chk_dec("rst_no_pulse", 8'h00);
    chk_hex("rst_no_pulse_hex", 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
